// File: rtl/bg_pkg.sv
// Shared types and widths for the background-removal frame controller.
package bg_pkg;

  localparam int unsigned CHAN_W = 8;
  localparam int unsigned DIST_W = 18;

  typedef enum logic [3:0] {
    StIdle,
    StSRd,
    StSLoad,
    StSGo,
    StSWait,
    StSAck,
    StMean,
    StBRd,
    StBLoad,
    StBGo,
    StBWait,
    StBWr,
    StFin
  } state_e;

  // Width of a per-block channel sum produced by the pe.
  function automatic int unsigned sum_w(input int unsigned num_pixels);
    return CHAN_W + $clog2(num_pixels + 1);
  endfunction

endpackage

// File: rtl/bg_mean_acc.sv
// Three-channel frame accumulator; latches acc >> Log2Total as the mean colour.
module bg_mean_acc
  import bg_pkg::*;
#(
  parameter int unsigned SumW      = 9,
  parameter int unsigned Log2Total = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic              latch_i,
  input  logic [SumW-1:0]   red_sum_i,
  input  logic [SumW-1:0]   green_sum_i,
  input  logic [SumW-1:0]   blue_sum_i,
  output logic [CHAN_W-1:0] red_mean_o,
  output logic [CHAN_W-1:0] green_mean_o,
  output logic [CHAN_W-1:0] blue_mean_o
);

  localparam int unsigned AccW = CHAN_W + Log2Total;

  logic [2:0][AccW-1:0]   acc_q, acc_d;
  logic [2:0][CHAN_W-1:0] mean_q, mean_d;
  logic [2:0][SumW-1:0]   sum;

  assign sum = {blue_sum_i, green_sum_i, red_sum_i};

  always_comb begin
    acc_d  = acc_q;
    mean_d = mean_q;
    for (int c = 0; c < 3; c++) begin
      if (clr_i) begin
        acc_d[c]  = '0;
        mean_d[c] = '0;
      end else begin
        if (add_i) begin
          acc_d[c] = acc_q[c] + AccW'(sum[c]);
        end
        // Truncating divide by the pixel count (a power of two).
        if (latch_i) begin
          mean_d[c] = acc_q[c][AccW-1:Log2Total];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      mean_q <= '0;
    end else begin
      acc_q  <= acc_d;
      mean_q <= mean_d;
    end
  end

  assign red_mean_o   = mean_q[0];
  assign green_mean_o = mean_q[1];
  assign blue_mean_o  = mean_q[2];

endmodule

// File: rtl/bg_frame_ctrl.sv
// Two-pass frame controller: sums every block to find the mean background colour,
// then replays each block through background removal and writes it back.
module bg_frame_ctrl
  import bg_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = 1,
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned LOG2_TOTAL = 2,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic [DIST_W-1:0]              threshold_cfg,
  input  logic [CHAN_W-1:0]              desired_bg_cfg,
  output logic                           Busy,
  output logic                           Done,
  output logic                           Err,
  output logic                           rd_en,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic [CHAN_W*NUM_PIXELS-1:0]   rd_red,
  input  logic [CHAN_W*NUM_PIXELS-1:0]   rd_green,
  input  logic [CHAN_W*NUM_PIXELS-1:0]   rd_blue,
  output logic                           wr_en,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [CHAN_W*NUM_PIXELS-1:0]   wr_red,
  output logic [CHAN_W*NUM_PIXELS-1:0]   wr_green,
  output logic [CHAN_W*NUM_PIXELS-1:0]   wr_blue,
  output logic [CHAN_W*NUM_PIXELS-1:0]   pe_red_in,
  output logic [CHAN_W*NUM_PIXELS-1:0]   pe_green_in,
  output logic [CHAN_W*NUM_PIXELS-1:0]   pe_blue_in,
  output logic [CHAN_W-1:0]              pe_red_exp,
  output logic [CHAN_W-1:0]              pe_green_exp,
  output logic [CHAN_W-1:0]              pe_blue_exp,
  output logic [DIST_W-1:0]              pe_threshold,
  output logic [CHAN_W-1:0]              pe_desired_bg,
  output logic                           Start_Sum,
  output logic                           Start_BgRemoval,
  output logic                           Ack,
  input  logic                           pe_Qsd,
  input  logic                           pe_Qbgd,
  input  logic [sum_w(NUM_PIXELS)-1:0]   pe_red_sum,
  input  logic [sum_w(NUM_PIXELS)-1:0]   pe_green_sum,
  input  logic [sum_w(NUM_PIXELS)-1:0]   pe_blue_sum,
  input  logic [CHAN_W*NUM_PIXELS-1:0]   pe_red_out,
  input  logic [CHAN_W*NUM_PIXELS-1:0]   pe_green_out,
  input  logic [CHAN_W*NUM_PIXELS-1:0]   pe_blue_out
);

  localparam int unsigned PixW = CHAN_W * NUM_PIXELS;
  localparam int unsigned SumW = sum_w(NUM_PIXELS);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LastBlk = ADDR_W'(NUM_BLOCKS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   blk_q, blk_d;
  logic [WdW-1:0]      wdog_q, wdog_d;
  logic                err_q, err_d;
  logic                ack_sent_q, ack_sent_d;
  logic [PixW-1:0]     red_in_q, red_in_d;
  logic [PixW-1:0]     green_in_q, green_in_d;
  logic [PixW-1:0]     blue_in_q, blue_in_d;
  logic [DIST_W-1:0]   thr_q, thr_d;
  logic [CHAN_W-1:0]   dbg_q, dbg_d;

  logic acc_clr, acc_add, acc_latch;
  logic wd_tick;

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    ack_sent_d = ack_sent_q;
    red_in_d   = red_in_q;
    green_in_d = green_in_q;
    blue_in_d  = blue_in_q;
    thr_d      = thr_q;
    dbg_d      = dbg_q;
    acc_clr         = 1'b0;
    acc_add         = 1'b0;
    acc_latch       = 1'b0;
    wd_tick         = 1'b0;
    rd_en           = 1'b0;
    wr_en           = 1'b0;
    Start_Sum       = 1'b0;
    Start_BgRemoval = 1'b0;
    Ack             = 1'b0;
    Done            = 1'b0;

    case (state_q)
      StIdle: begin
        if (Start) begin
          acc_clr = 1'b1;
          blk_d   = '0;
          err_d   = 1'b0;
          thr_d   = threshold_cfg;
          dbg_d   = desired_bg_cfg;
          state_d = StSRd;
        end
      end
      StSRd, StBRd: begin
        rd_en   = 1'b1;
        state_d = (state_q == StSRd) ? StSLoad : StBLoad;
      end
      StSLoad, StBLoad: begin
        red_in_d   = rd_red;
        green_in_d = rd_green;
        blue_in_d  = rd_blue;
        state_d    = (state_q == StSLoad) ? StSGo : StBGo;
      end
      StSGo: begin
        Start_Sum = 1'b1;
        wdog_d    = WdW'(TIMEOUT);
        state_d   = StSWait;
      end
      StBGo: begin
        Start_BgRemoval = 1'b1;
        wdog_d          = WdW'(TIMEOUT);
        state_d         = StBWait;
      end
      StSWait: begin
        if (pe_Qsd) begin
          acc_add    = 1'b1;
          ack_sent_d = 1'b0;
          state_d    = StSAck;
        end else begin
          wd_tick = 1'b1;
        end
      end
      StSAck: begin
        Ack        = ~ack_sent_q;
        ack_sent_d = 1'b1;
        if (!pe_Qsd) begin
          if (blk_q == LastBlk) begin
            state_d = StMean;
          end else begin
            blk_d   = blk_q + ADDR_W'(1);
            state_d = StSRd;
          end
        end else begin
          wd_tick = 1'b1;
        end
      end
      StMean: begin
        acc_latch = 1'b1;
        blk_d     = '0;
        state_d   = StBRd;
      end
      StBWait: begin
        if (pe_Qbgd) begin
          ack_sent_d = 1'b0;
          state_d    = StBWr;
        end else begin
          wd_tick = 1'b1;
        end
      end
      StBWr: begin
        // Write and Ack only on the first cycle; the rest is the done-drop hold.
        wr_en      = ~ack_sent_q;
        Ack        = ~ack_sent_q;
        ack_sent_d = 1'b1;
        if (!pe_Qbgd) begin
          if (blk_q == LastBlk) begin
            state_d = StFin;
          end else begin
            blk_d   = blk_q + ADDR_W'(1);
            state_d = StBRd;
          end
        end else begin
          wd_tick = 1'b1;
        end
      end
      StFin: begin
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (wd_tick) begin
      if (wdog_q == '0) begin
        err_d   = 1'b1;
        Ack     = 1'b1;
        state_d = StFin;
      end else begin
        wdog_d = wdog_q - WdW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      ack_sent_q <= 1'b0;
      red_in_q   <= '0;
      green_in_q <= '0;
      blue_in_q  <= '0;
      thr_q      <= '0;
      dbg_q      <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      ack_sent_q <= ack_sent_d;
      red_in_q   <= red_in_d;
      green_in_q <= green_in_d;
      blue_in_q  <= blue_in_d;
      thr_q      <= thr_d;
      dbg_q      <= dbg_d;
    end
  end

  bg_mean_acc #(
    .SumW      (SumW),
    .Log2Total (LOG2_TOTAL)
  ) u_mean_acc (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .clr_i        (acc_clr),
    .add_i        (acc_add),
    .latch_i      (acc_latch),
    .red_sum_i    (pe_red_sum),
    .green_sum_i  (pe_green_sum),
    .blue_sum_i   (pe_blue_sum),
    .red_mean_o   (pe_red_exp),
    .green_mean_o (pe_green_exp),
    .blue_mean_o  (pe_blue_exp)
  );

  assign Busy          = (state_q != StIdle) && (state_q != StFin);
  assign Err           = err_q;
  assign rd_addr       = rd_en ? blk_q : '0;
  assign wr_addr       = wr_en ? blk_q : '0;
  assign wr_red        = wr_en ? pe_red_out : '0;
  assign wr_green      = wr_en ? pe_green_out : '0;
  assign wr_blue       = wr_en ? pe_blue_out : '0;
  assign pe_red_in     = red_in_q;
  assign pe_green_in   = green_in_q;
  assign pe_blue_in    = blue_in_q;
  assign pe_threshold  = thr_q;
  assign pe_desired_bg = dbg_q;

endmodule

// File: tb/tb_bg_frame_ctrl.sv
// Directed bench for bg_frame_ctrl with a behavioural pe and frame memory.
module tb_bg_frame_ctrl;

  localparam int unsigned NP  = 2;
  localparam int unsigned NB  = 2;
  localparam int unsigned L2T = 2;
  localparam int unsigned AW  = 8;
  localparam int unsigned TO  = 20;
  localparam int unsigned PW  = 8 * NP;
  localparam int unsigned SW  = 10;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [17:0]   threshold_cfg = 18'd5000;
  logic [7:0]    desired_bg_cfg = 8'h2a;
  logic          Busy, Done, Err, rd_en, wr_en, Start_Sum, Start_BgRemoval, Ack;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [PW-1:0] rd_red, rd_green, rd_blue;
  logic [PW-1:0] wr_red, wr_green, wr_blue;
  logic [PW-1:0] pe_red_in, pe_green_in, pe_blue_in;
  logic [PW-1:0] pe_red_out, pe_green_out, pe_blue_out;
  logic [7:0]    pe_red_exp, pe_green_exp, pe_blue_exp, pe_desired_bg;
  logic [17:0]   pe_threshold;
  logic          pe_Qsd, pe_Qbgd;
  logic [SW-1:0] pe_red_sum, pe_green_sum, pe_blue_sum;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  bg_frame_ctrl #(
    .NUM_PIXELS (NP),
    .NUM_BLOCKS (NB),
    .LOG2_TOTAL (L2T),
    .ADDR_W     (AW),
    .TIMEOUT    (TO)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Start           (Start),
    .threshold_cfg   (threshold_cfg),
    .desired_bg_cfg  (desired_bg_cfg),
    .Busy            (Busy),
    .Done            (Done),
    .Err             (Err),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_red          (rd_red),
    .rd_green        (rd_green),
    .rd_blue         (rd_blue),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_red          (wr_red),
    .wr_green        (wr_green),
    .wr_blue         (wr_blue),
    .pe_red_in       (pe_red_in),
    .pe_green_in     (pe_green_in),
    .pe_blue_in      (pe_blue_in),
    .pe_red_exp      (pe_red_exp),
    .pe_green_exp    (pe_green_exp),
    .pe_blue_exp     (pe_blue_exp),
    .pe_threshold    (pe_threshold),
    .pe_desired_bg   (pe_desired_bg),
    .Start_Sum       (Start_Sum),
    .Start_BgRemoval (Start_BgRemoval),
    .Ack             (Ack),
    .pe_Qsd          (pe_Qsd),
    .pe_Qbgd         (pe_Qbgd),
    .pe_red_sum      (pe_red_sum),
    .pe_green_sum    (pe_green_sum),
    .pe_blue_sum     (pe_blue_sum),
    .pe_red_out      (pe_red_out),
    .pe_green_out    (pe_green_out),
    .pe_blue_out     (pe_blue_out)
  );

  // Frame memory: one-cycle read latency, write capture.
  logic [PW-1:0] mem_r [2];
  logic [PW-1:0] mem_g [2];
  logic [PW-1:0] mem_b [2];
  logic [PW-1:0] wm_r [2];
  logic [PW-1:0] wm_g [2];
  logic [PW-1:0] wm_b [2];

  always @(posedge Clk) begin
    if (rd_en) begin
      rd_red   <= mem_r[rd_addr[0]];
      rd_green <= mem_g[rd_addr[0]];
      rd_blue  <= mem_b[rd_addr[0]];
    end
    if (wr_en) begin
      wm_r[wr_addr[0]] <= wr_red;
      wm_g[wr_addr[0]] <= wr_green;
      wm_b[wr_addr[0]] <= wr_blue;
    end
  end

  // Behavioural pe: done flag two cycles after the start pulse, drops
  // pe_drop_extra+1 cycles after the Ack.
  int   pe_busy = 0;
  int   pe_hold = -1;
  int   pe_drop_extra = 0;
  logic pe_bg = 1'b0;
  logic pe_never_qsd = 1'b0;

  function automatic logic [SW-1:0] sum2(input logic [PW-1:0] v);
    return SW'(v[7:0]) + SW'(v[15:8]);
  endfunction

  function automatic logic [PW-1:0] bg_blk(input int ch);
    logic [PW-1:0] res;
    logic [7:0]    keep;
    int dr, dg, db;
    res = '0;
    for (int p = 0; p < int'(NP); p++) begin
      dr = int'(pe_red_in[8*p +: 8]) - int'(pe_red_exp);
      dg = int'(pe_green_in[8*p +: 8]) - int'(pe_green_exp);
      db = int'(pe_blue_in[8*p +: 8]) - int'(pe_blue_exp);
      keep = (ch == 0) ? pe_red_in[8*p +: 8] :
             (ch == 1) ? pe_green_in[8*p +: 8] : pe_blue_in[8*p +: 8];
      res[8*p +: 8] = (dr*dr + dg*dg + db*db < int'(pe_threshold)) ? pe_desired_bg : keep;
    end
    return res;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      pe_Qsd       <= 1'b0;
      pe_Qbgd      <= 1'b0;
      pe_busy      <= 0;
      pe_hold      <= -1;
      pe_bg        <= 1'b0;
      pe_red_sum   <= '0;
      pe_green_sum <= '0;
      pe_blue_sum  <= '0;
      pe_red_out   <= '0;
      pe_green_out <= '0;
      pe_blue_out  <= '0;
    end else begin
      if (Start_Sum || Start_BgRemoval) begin
        pe_bg   <= Start_BgRemoval;
        pe_busy <= 2;
      end else if (pe_busy > 0) begin
        pe_busy <= pe_busy - 1;
        if (pe_busy == 1) begin
          if (pe_bg) begin
            pe_Qbgd      <= 1'b1;
            pe_red_out   <= bg_blk(0);
            pe_green_out <= bg_blk(1);
            pe_blue_out  <= bg_blk(2);
          end else if (!pe_never_qsd) begin
            pe_Qsd       <= 1'b1;
            pe_red_sum   <= sum2(pe_red_in);
            pe_green_sum <= sum2(pe_green_in);
            pe_blue_sum  <= sum2(pe_blue_in);
          end
        end
      end
      if (Ack && (pe_Qsd || pe_Qbgd)) begin
        pe_hold <= pe_drop_extra;
      end else if (pe_hold == 0) begin
        pe_Qsd  <= 1'b0;
        pe_Qbgd <= 1'b0;
        pe_hold <= -1;
      end else if (pe_hold > 0) begin
        pe_hold <= pe_hold - 1;
      end
    end
  end

  // Event counters sampled mid-cycle.
  int cyc = 0;
  int ss_cnt = 0, sb_cnt = 0, wr_cnt = 0, done_cnt = 0, ack_cnt = 0, viol = 0;
  int ss_cyc = 0, wr_cyc = 0, done_cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Start_Sum) begin
      ss_cnt <= ss_cnt + 1;
      ss_cyc <= cyc;
    end
    if (Start_BgRemoval) begin
      sb_cnt <= sb_cnt + 1;
      if (pe_Qbgd) viol <= viol + 1;
    end
    if (wr_en) begin
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
    end
    if (Done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (Ack) ack_cnt <= ack_cnt + 1;
  end

  logic any_out;
  assign any_out = |{Busy, Done, Err, rd_en, rd_addr, wr_en, wr_addr, wr_red, wr_green, wr_blue,
                     pe_red_in, pe_green_in, pe_blue_in, pe_red_exp, pe_green_exp, pe_blue_exp,
                     pe_threshold, pe_desired_bg, Start_Sum, Start_BgRemoval, Ack};

  int b_ss, b_sb, b_wr, b_done, b_ack, b_viol;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_ss   = ss_cnt;
    b_sb   = sb_cnt;
    b_wr   = wr_cnt;
    b_done = done_cnt;
    b_ack  = ack_cnt;
    b_viol = viol;
  endtask

  // pattern 0: every pixel (100,100,100); pattern 1: red 0,255,255,255.
  task automatic load_frame(input int pat);
    for (int i = 0; i < 2; i++) begin
      mem_r[i] = 16'h6464;
      mem_g[i] = 16'h6464;
      mem_b[i] = 16'h6464;
    end
    if (pat == 1) begin
      mem_r[0] = 16'hff00;
      mem_r[1] = 16'hffff;
    end
  endtask

  task automatic wait_done(output int ok);
    ok = 0;
    for (int i = 0; i < 3000 && ok == 0; i++) begin
      @(negedge Clk);
      if (Done) ok = 1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(output int ok);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    wait_done(ok);
  endtask

  initial begin
    int ok;
    int k;

    load_frame(0);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_outputs_zero", 64'(any_out), 64'd0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk("idle_busy", 64'(Busy), 64'd0);

    // Frame 1: uniform background.
    snap();
    run_frame(ok);
    chk("f1_done_seen", 64'(ok), 64'd1);
    chk("f1_start_sum", 64'(ss_cnt - b_ss), 64'd2);
    chk("f1_start_bg", 64'(sb_cnt - b_sb), 64'd2);
    chk("f1_writes", 64'(wr_cnt - b_wr), 64'd2);
    chk("f1_done_cnt", 64'(done_cnt - b_done), 64'd1);
    chk("f1_done_after_wr", 64'(done_cyc > wr_cyc), 64'd1);
    chk("f1_exp", 64'({pe_red_exp, pe_green_exp, pe_blue_exp}), 64'h646464);
    chk("f1_err", 64'(Err), 64'd0);
    chk("f1_wr_blk0", 64'({wm_r[0], wm_g[0], wm_b[0]}), 64'h2a2a_2a2a_2a2a);
    chk("f1_wr_blk1", 64'({wm_r[1], wm_g[1], wm_b[1]}), 64'h2a2a_2a2a_2a2a);
    chk("f1_cfg", 64'({pe_threshold, pe_desired_bg}), 64'({18'd5000, 8'h2a}));

    // Frame 2: red mean 765>>2 = 191.
    load_frame(1);
    desired_bg_cfg = 8'h07;
    snap();
    run_frame(ok);
    chk("f2_done_seen", 64'(ok), 64'd1);
    chk("f2_exp", 64'({pe_red_exp, pe_green_exp, pe_blue_exp}), 64'hbf6464);
    chk("f2_wr_blk0", 64'({wm_r[0], wm_g[0], wm_b[0]}), 64'h0700_0764_0764);
    chk("f2_wr_blk1", 64'({wm_r[1], wm_g[1], wm_b[1]}), 64'h0707_0707_0707);
    chk("f2_desired", 64'(pe_desired_bg), 64'h07);

    // Frame 3: pe never finishes the sum.
    pe_never_qsd = 1'b1;
    snap();
    run_frame(ok);
    pe_never_qsd = 1'b0;
    chk("f3_done_seen", 64'(ok), 64'd1);
    chk("f3_err", 64'(Err), 64'd1);
    chk("f3_done_latency", 64'(done_cyc - ss_cyc), 64'(TO + 2));
    chk("f3_no_writes", 64'(wr_cnt - b_wr), 64'd0);
    chk("f3_start_sum", 64'(ss_cnt - b_ss), 64'd1);
    chk("f3_ack_once", 64'(ack_cnt - b_ack), 64'd1);
    chk("f3_done_cnt", 64'(done_cnt - b_done), 64'd1);

    // Frame 4: Start re-pulsed while busy is ignored; Err clears on accept.
    load_frame(0);
    snap();
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk("f4_err_cleared", 64'(Err), 64'd0);
    chk("f4_busy", 64'(Busy), 64'd1);
    repeat (4) @(posedge Clk);
    #1;
    Start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Start = 1'b0;
    wait_done(ok);
    repeat (30) @(posedge Clk);
    #1;
    chk("f4_done_seen", 64'(ok), 64'd1);
    chk("f4_done_cnt", 64'(done_cnt - b_done), 64'd1);
    chk("f4_start_sum", 64'(ss_cnt - b_ss), 64'd2);
    chk("f4_idle_after", 64'(Busy), 64'd0);

    // Frame 5: done flags linger three extra cycles after Ack.
    pe_drop_extra = 3;
    snap();
    run_frame(ok);
    pe_drop_extra = 0;
    chk("f5_done_seen", 64'(ok), 64'd1);
    chk("f5_start_bg", 64'(sb_cnt - b_sb), 64'd2);
    chk("f5_writes", 64'(wr_cnt - b_wr), 64'd2);
    chk("f5_bg_while_qbgd", 64'(viol - b_viol), 64'd0);
    chk("f5_wr_blk1", 64'({wm_r[1], wm_g[1], wm_b[1]}), 64'h0707_0707_0707);

    // Frame 6: reset during B_WAIT of block 1, then a clean frame.
    load_frame(1);
    snap();
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    k = 0;
    for (int i = 0; i < 500 && k < 2; i++) begin
      @(negedge Clk);
      if (Start_BgRemoval) k++;
    end
    chk("f6_reach_bwait", 64'(k), 64'd2);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("f6_rst_outputs_zero", 64'(any_out), 64'd0);
    chk("f6_abort_writes", 64'(wr_cnt - b_wr), 64'd1);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    snap();
    run_frame(ok);
    chk("f6_done_seen", 64'(ok), 64'd1);
    chk("f6_writes", 64'(wr_cnt - b_wr), 64'd2);
    chk("f6_done_cnt", 64'(done_cnt - b_done), 64'd1);
    chk("f6_exp", 64'({pe_red_exp, pe_green_exp, pe_blue_exp}), 64'hbf6464);
    chk("f6_wr_blk0", 64'({wm_r[0], wm_g[0], wm_b[0]}), 64'h0700_0764_0764);
    chk("f6_err", 64'(Err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_frame_ctrl.md
Name: bg_frame_ctrl

Overview:
- Control unit that drives one background-removal processing element (pe) through a full frame in two passes.
- Pass 1: streams pixel blocks from frame memory into the pe's sum operation, accumulates per-channel totals, and computes the mean background colour.
- Pass 2: replays every block through the pe's background-removal operation with that mean as the expected colour, and writes the results back to frame memory.
- Sits between the frame buffer and the pe, and owns the Start_Sum / Start_BgRemoval / Ack handshake.

Parameters:
- NUM_PIXELS, 1, pixels per block; matches the pe's num_pixels.
- NUM_BLOCKS, 4, blocks per frame; NUM_PIXELS*NUM_BLOCKS must be a power of two.
- LOG2_TOTAL, 2, log2(NUM_PIXELS*NUM_BLOCKS).
- ADDR_W, 8, block address width.
- TIMEOUT, 255, max cycles to wait for a pe done flag.

Ports:
- Clk  in  1  clock; one clock domain.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin frame; sampled in IDLE only.
- threshold_cfg  in  18  distance² threshold, forwarded to the pe.
- desired_bg_cfg  in  8  replacement value, forwarded to the pe.
- Busy  out  1  high from Start accepted until Done.
- Done  out  1  one-cycle pulse at frame end.
- Err  out  1  sticky timeout flag; cleared on the next accepted Start.
- rd_en  out  1  frame memory read; data returns one cycle later.
- rd_addr  out  ADDR_W  block address.
- rd_red/rd_green/rd_blue  in  8*NUM_PIXELS each  block data.
- wr_en  out  1  frame memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_red/wr_green/wr_blue  out  8*NUM_PIXELS each  processed block.
- pe_red_in/pe_green_in/pe_blue_in  out  8*NUM_PIXELS each  block held for the pe.
- pe_red_exp/pe_green_exp/pe_blue_exp  out  8 each  mean colour.
- pe_threshold  out  18  threshold to the pe.
- pe_desired_bg  out  8  replacement value to the pe.
- Start_Sum, Start_BgRemoval, Ack  out  1 each  single-cycle pulses to the pe.
- pe_Qsd, pe_Qbgd  in  1 each  pe done flags.
- pe_red_sum/pe_green_sum/pe_blue_sum  in  8+clog2(NUM_PIXELS+1) each  block sums.
- pe_red_out/pe_green_out/pe_blue_out  in  8*NUM_PIXELS each  pe results.

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulators 0, block counter 0, Err 0.
  - Reset mid-frame aborts immediately.
  - No Ack is issued on abort; the pe is reset by the same Reset.
- States: IDLE, S_RD, S_LOAD, S_GO, S_WAIT, S_ACK, MEAN, B_RD, B_LOAD, B_GO, B_WAIT, B_WR, FIN.
- IDLE: Start=1 → clear accumulators, block counter and Err; set Busy; go to S_RD. Start outside IDLE is ignored.
- S_RD: rd_en=1, rd_addr=blk.
- S_LOAD: register rd_* into pe_*_in; go to S_GO.
- S_GO: Start_Sum=1 for one cycle; load the watchdog with TIMEOUT.
- S_WAIT: on pe_Qsd=1, add pe_*_sum to the 8+LOG2_TOTAL-bit accumulators and go to S_ACK.
- S_ACK: Ack=1 for one cycle; hold until pe_Qsd=0.
  - If blk==NUM_BLOCKS-1 → MEAN.
  - Otherwise blk+1 → S_RD.
- MEAN: pe_*_exp = acc>>LOG2_TOTAL, truncated, no rounding; held stable through pass 2. blk=0; go to B_RD.
- B_RD, B_LOAD, B_GO: same as S_RD, S_LOAD, S_GO, but pulse Start_BgRemoval.
- B_WAIT: wait for pe_Qbgd=1.
- B_WR (one cycle): wr_en=1, wr_addr=blk, wr_*=pe_*_out; Ack=1 in the same cycle.
  - Hold until pe_Qbgd=0.
  - If last block → FIN; otherwise blk+1 → B_RD.
- FIN: Done=1 for one cycle, Busy=0 → IDLE.
- Watchdog: decrements every cycle in S_WAIT/B_WAIT (and in the done-drop holds of S_ACK/B_WR).
  - At 0: Err=1, Ack pulsed once, → FIN.
  - The frame ends early with Done still pulsed; wr_en is not asserted for the failed block.
- A done flag that is already high in the cycle of the Start_* pulse is ignored; only the flag sampled in a later cycle counts.
- pe_threshold and pe_desired_bg are registered copies of the cfg inputs, captured when Start is accepted and stable for the frame.
- Accumulator width guarantees no overflow: maximum 255*2^LOG2_TOTAL.

Decomposition:
- Package bg_pkg holds:
  - the state enum;
  - CHAN_W=8 and DIST_W=18;
  - the helper function computing sum width.
- Sub-module bg_mean_acc: three-channel accumulator with clear/add/shift-out.

Test Plan:
- NUM_PIXELS=2, NUM_BLOCKS=2, all pixels (100,100,100), behavioural pe model → exp=(100,100,100); 2 Start_Sum, 2 Start_BgRemoval, 2 writes; Done after the last write; Err=0.
- Pixel red values 0,255,255,255 → red_exp=191 (765>>2, truncated).
- pe model never raises Qsd → Err=1 and Done exactly TIMEOUT+1 cycles after S_WAIT is entered; wr_en never asserted.
- Start pulsed again while Busy → ignored; exactly one frame is processed and exactly one Done pulse occurs.
- Reset asserted during B_WAIT of block 1 → next cycle all outputs 0 and state IDLE; a new Start then runs a full frame correctly.
- pe holds Qbgd high 3 cycles after Ack → controller waits; no extra Start_BgRemoval or wr_en occurs until Qbgd=0.
